// File: rtl/dct_2d_row_sched_if.sv
// Row-in / column-out stream bundle for the 16-point 2-D DCT row scheduler.
// The scheduler sits on the slave modport; the environment sits on master.
interface dct_2d_row_sched_if #(
    parameter int N  = 16,
    parameter int PW = 8,
    parameter int BW = 11
);
    // valid/ready: a transfer happens on a rising clk edge where both valid and ready are 1;
    // once valid is raised the payload holds stable and valid stays high until that transfer.
    logic              in_valid;
    logic              in_ready;
    logic [N*PW-1:0]   in_row;
    logic [N*PW-1:0]   dct_row_in;
    logic [N*BW-1:0]   dct_row_out;
    logic              out_valid;
    logic              out_ready;
    logic [N*BW-1:0]   out_col;
    logic [3:0]        out_col_idx;
    logic              out_last;
    logic              blk_done;

    modport master (
        output in_valid, in_row, dct_row_out, out_ready,
        input  in_ready, dct_row_in, out_valid, out_col, out_col_idx, out_last, blk_done
    );

    modport slave (
        input  in_valid, in_row, dct_row_out, out_ready,
        output in_ready, dct_row_in, out_valid, out_col, out_col_idx, out_last, blk_done
    );
endinterface

// File: rtl/dct_2d_row_sched.sv
// Load/drain sequencer and 16x16 transpose buffer between the row and column DCT stages.
// Optional macro DCT_PIPE_REG_EN registers the row-DCT result and adds a FLUSH state.
module dct_2d_row_sched #(
    parameter int N  = 16,
    parameter int BW = 11
) (
    input  logic                 clk,
    input  logic                 rstn,
    dct_2d_row_sched_if.slave    bus,
    output logic [1:0]           dbg_state
);
    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]     state;
    logic [3:0]     row_cnt;
    logic [3:0]     col_cnt;
    logic [BW-1:0]  tbuf [N][N];

    logic           in_fire;
    logic           out_fire;
    logic           wr_en;
    logic [3:0]     wr_idx;
    logic [N*BW-1:0] wr_row;

    assign bus.in_ready    = rstn && (state == ST_LOAD);
    assign bus.out_valid   = (state == ST_DRAIN);
    assign bus.dct_row_in  = bus.in_row;
    assign bus.out_col_idx = col_cnt;
    assign bus.out_last    = bus.out_valid && (col_cnt == 4'd15);
    assign bus.blk_done    = out_fire && (col_cnt == 4'd15);
    assign dbg_state       = state;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

`ifdef DCT_PIPE_REG_EN
    // Row-DCT result is retimed one cycle; the last row lands during FLUSH.
    localparam logic [1:0] ST_AFTER_LOAD = ST_FLUSH;

    logic            pipe_we;
    logic [3:0]      pipe_idx;
    logic [N*BW-1:0] pipe_row;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pipe_we <= 1'b0;
        else       pipe_we <= in_fire;
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            pipe_idx <= row_cnt;
            pipe_row <= bus.dct_row_out;
        end
    end

    assign wr_en  = pipe_we;
    assign wr_idx = pipe_idx;
    assign wr_row = pipe_row;
`else
    localparam logic [1:0] ST_AFTER_LOAD = ST_DRAIN;

    assign wr_en  = in_fire;
    assign wr_idx = row_cnt;
    assign wr_row = bus.dct_row_out;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_LOAD;
            row_cnt <= 4'd0;
            col_cnt <= 4'd0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_fire) begin
                        row_cnt <= row_cnt + 4'd1;
                        if (row_cnt == 4'd15) state <= ST_AFTER_LOAD;
                    end
                end
                ST_FLUSH: state <= ST_DRAIN;
                ST_DRAIN: begin
                    if (out_fire) begin
                        col_cnt <= col_cnt + 4'd1;
                        if (col_cnt == 4'd15) state <= ST_LOAD;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    // Row r of the buffer holds the N coefficients of input row r; X_0 sits in the MSB slice.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < N; r++) begin
                for (int k = 0; k < N; k++) begin
                    tbuf[r][k] <= '0;
                end
            end
        end else if (wr_en) begin
            for (int k = 0; k < N; k++) begin
                tbuf[wr_idx][k] <= wr_row[(N-1-k)*BW +: BW];
            end
        end
    end

    always_comb begin
        bus.out_col = '0;
        for (int r = 0; r < N; r++) begin
            bus.out_col[(N-1-r)*BW +: BW] = tbuf[r][col_cnt];
        end
    end
endmodule

// File: tb/tb_dct_2d_row_sched.sv
// Bench for dct_2d_row_sched: stub and cosine row-DCT models, transpose scoreboard,
// input gaps, output stalls and mid-drain reset.
module tb_dct_2d_row_sched;
    localparam int N  = 16;
    localparam int PW = 8;
    localparam int BW = 11;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dct_2d_row_sched_if #(.N(N), .PW(PW), .BW(BW)) bus ();
    logic [1:0] dbg_state;

    dct_2d_row_sched #(.N(N), .BW(BW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int tests_run = 0;
    int tests_failed = 0;

    logic [N*BW-1:0] exp_q [$];
    logic [N*BW-1:0] stub_tab [N];
    logic [N*PW-1:0] pix [N];
    int              stub_row = 0;
    bit              mode_real = 1'b0;
    int              hs_cnt = 0;

    // Reference row DCT: X_k = 1/4 * sum_n x_n cos(pi*(2n+1)k/32), rounded to nearest.
    function automatic logic [N*BW-1:0] dct_row(input logic [N*PW-1:0] row);
        logic [N*BW-1:0] res;
        real acc;
        int  v;
        res = '0;
        for (int k = 0; k < N; k++) begin
            acc = 0.0;
            for (int n = 0; n < N; n++) begin
                acc = acc + real'(row[(N-1-n)*PW +: PW]) *
                      $cos(3.14159265358979 * real'((2*n+1)*k) / 32.0);
            end
            acc = acc / 4.0;
            v = (acc >= 0.0) ? $rtoi(acc + 0.5) : -$rtoi(-acc + 0.5);
            res[(N-1-k)*BW +: BW] = v[BW-1:0];
        end
        return res;
    endfunction

    assign bus.dct_row_out = mode_real ? dct_row(bus.dct_row_in) : stub_tab[stub_row];

    always @(negedge clk) begin
        if (rstn && bus.in_valid && bus.in_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic fill_pix_random();
        logic [PW-1:0] p;
        for (int r = 0; r < N; r++) begin
            for (int n = 0; n < N; n++) begin
                p = PW'($urandom_range(0, 255));
                pix[r][(N-1-n)*PW +: PW] = p;
            end
        end
    endtask

    task automatic fill_stub_random();
        logic [BW-1:0] v;
        mode_real = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < N; k++) begin
                v = BW'($urandom_range(0, 2047));
                stub_tab[r][(N-1-k)*BW +: BW] = v;
            end
        end
    endtask

    task automatic fill_real();
        mode_real = 1'b1;
        for (int r = 0; r < N; r++) stub_tab[r] = dct_row(pix[r]);
    endtask

    // Expected output is the transpose of the coefficient matrix, one column per entry.
    task automatic expect_block();
        logic [N*BW-1:0] col;
        for (int c = 0; c < N; c++) begin
            col = '0;
            for (int r = 0; r < N; r++) col[(N-1-r)*BW +: BW] = stub_tab[r][(N-1-c)*BW +: BW];
            exp_q.push_back(col);
        end
    endtask

    task automatic load_block(input int gap);
        int hs0;
        int n;
        hs0 = hs_cnt;
        expect_block();
        for (int r = 0; r < N; r++) begin
            bus.in_row = pix[r];
            stub_row = r;
            bus.in_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!bus.in_ready && n < 50) begin
                n++;
                @(negedge clk);
            end
            tests_run++;
            if (n >= 50) begin
                tests_failed++;
                $display("FAIL load_timeout: row %0d in_ready stayed %b, required 1", r, bus.in_ready);
                bus.in_valid = 1'b0;
                return;
            end
            if (r == 0 || r == 15) begin
                tests_run++;
                if (bus.dct_row_in !== pix[r]) begin
                    tests_failed++;
                    $display("FAIL dct_row_in: got %h required %h", bus.dct_row_in, pix[r]);
                end
            end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            if (r < N-1) repeat (gap) begin @(posedge clk); #1; end
        end
        @(negedge clk);
`ifdef DCT_PIPE_REG_EN
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_cycle: out_valid=%b in_ready=%b, required 0 0", bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
`endif
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_out_latency: out_valid=%b in_ready=%b, required 1 0", bus.out_valid, bus.in_ready);
        end
        tests_run++;
        if (hs_cnt - hs0 != 16) begin
            tests_failed++;
            $display("FAIL handshake_count: got %0d required 16", hs_cnt - hs0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain_block(input int stall_col, input int stall_len, input int abort_col);
        logic [N*BW-1:0] exp_col;
        int n;
        for (int c = 0; c < N; c++) begin
            n = 0;
            while (!bus.out_valid && n < 50) begin
                n++;
                @(posedge clk);
                #1;
            end
            tests_run++;
            if (n >= 50 || exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL drain_timeout: col %0d out_valid=%b queued=%0d", c, bus.out_valid, exp_q.size());
                return;
            end
            exp_col = exp_q.pop_front();
            if (c == abort_col) begin
                rstn = 1'b0;
                #1;
                if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL abort_reset: out_valid=%b in_ready=%b, required 0 0", bus.out_valid, bus.in_ready);
                end
                bus.out_ready = 1'b0;
                @(posedge clk);
                #1;
                rstn = 1'b1;
                @(posedge clk);
                #1;
                tests_run++;
                if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_col_idx !== 4'd0) begin
                    tests_failed++;
                    $display("FAIL abort_recover: out_valid=%b in_ready=%b idx=%0d, required 0 1 0",
                             bus.out_valid, bus.in_ready, bus.out_col_idx);
                end
                exp_q.delete();
                return;
            end
            if (c == stall_col) begin
                bus.out_ready = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    tests_run++;
                    if (bus.out_valid !== 1'b1 || bus.out_col_idx !== 4'(c) || bus.out_col !== exp_col ||
                        bus.in_ready !== 1'b0 || bus.blk_done !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL stall_hold: c=%0d valid=%b idx=%0d in_ready=%b col=%h required col=%h",
                                 c, bus.out_valid, bus.out_col_idx, bus.in_ready, bus.out_col, exp_col);
                    end
                    @(posedge clk);
                    #1;
                end
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            if (bus.out_col !== exp_col) begin
                tests_failed++;
                $display("FAIL out_col: c=%0d got %h required %h", c, bus.out_col, exp_col);
            end
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_col_idx !== 4'(c) || bus.out_last !== (c == 15) ||
                bus.blk_done !== (c == 15) || bus.in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL col_flags: c=%0d valid=%b idx=%0d last=%b done=%b in_ready=%b",
                         c, bus.out_valid, bus.out_col_idx, bus.out_last, bus.blk_done, bus.in_ready);
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
        end
        @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.blk_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL back_to_load: out_valid=%b in_ready=%b blk_done=%b, required 0 1 0",
                     bus.out_valid, bus.in_ready, bus.blk_done);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_row = '0;
        bus.out_ready = 1'b0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_active: in_ready=%b out_valid=%b, required 0 0", bus.in_ready, bus.out_valid);
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_col !== '0 ||
            bus.out_col_idx !== 4'd0 || bus.blk_done !== 1'b0 || bus.out_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b col=%h idx=%0d done=%b last=%b",
                     bus.in_ready, bus.out_valid, bus.out_col, bus.out_col_idx, bus.blk_done, bus.out_last);
        end
    endtask

    task automatic test_transpose();
        fill_pix_random();
        mode_real = 1'b0;
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) stub_tab[r][(N-1-k)*BW +: BW] = BW'(r*16 + k);
        load_block(0);
        drain_block(-1, 0, -1);
    endtask

    task automatic test_real_dct_flat();
        logic [N*BW-1:0] col0;
        for (int r = 0; r < N; r++) pix[r] = {N{8'd128}};
        fill_real();
        for (int r = 0; r < N; r++) col0[(N-1-r)*BW +: BW] = 11'd512;
        tests_run++;
        if (stub_tab[0] !== {11'd512, {(N-1)*BW{1'b0}}}) begin
            tests_failed++;
            $display("FAIL flat_model: got %h", stub_tab[0]);
        end
        load_block(0);
        tests_run++;
        if (exp_q.size() != N || exp_q[0] !== col0) begin
            tests_failed++;
            $display("FAIL flat_col0_expect: queued=%0d", exp_q.size());
        end
        drain_block(-1, 0, -1);
    endtask

    task automatic test_gapped_input();
        fill_pix_random();
        fill_stub_random();
        load_block(2);
        drain_block(-1, 0, -1);
    endtask

    task automatic test_stall();
        fill_pix_random();
        fill_stub_random();
        load_block(0);
        drain_block(7, 5, -1);
    endtask

    task automatic test_abort();
        fill_pix_random();
        fill_stub_random();
        load_block(1);
        drain_block(-1, 0, 9);
        fill_pix_random();
        fill_stub_random();
        load_block(0);
        drain_block(-1, 0, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            fill_pix_random();
            if ($urandom_range(0, 1) == 1) fill_real();
            else fill_stub_random();
            load_block(int'($urandom_range(0, 2)));
            drain_block(int'($urandom_range(0, 15)), int'($urandom_range(1, 4)), -1);
        end
    endtask

    initial begin
        test_reset();
        test_transpose();
        test_real_dct_flat();
        test_gapped_input();
        test_stall();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end
endmodule
